// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, response error codes,
// FSM states and the request legality check.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_SIZE     = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    RDWAIT,
    MERGE,
    RESP
  } state_e;

  // Priority: illegal size beats misalignment beats out-of-range.
  function automatic logic [1:0] check_req(input logic [1:0]  size,
                                           input logic [31:0] addr,
                                           input logic [32:0] limit);
    logic [1:0] err;
    err = ERR_OK;
    if (size == ERR_SIZE)
      err = ERR_SIZE;
    else if ((size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00))
      err = ERR_MISALIGN;
    else if ({1'b0, addr} >= limit)
      err = ERR_RANGE;
    return err;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request, response and data-memory signals of the load/store unit.
// slave = the LSU itself; master = execute stage plus memory side.
interface lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;

  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output mem_addr, mem_re, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  mem_addr, mem_re, mem_we, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load extraction with sign/zero extension and
// sub-word store merge into the word read back from memory.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_offs,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_st_data
);

  logic [31:0] w_shift;

  // Aligned halfwords have offset 0 or 2, so the same shift serves bytes and halves.
  assign w_shift = i_rdata >> {i_offs, 3'b000};

  always_comb begin
    o_ld_data = i_rdata;
    case (i_size)
      SZ_BYTE: o_ld_data = {{24{~i_unsigned & w_shift[7]}},  w_shift[7:0]};
      SZ_HALF: o_ld_data = {{16{~i_unsigned & w_shift[15]}}, w_shift[15:0]};
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic       w_sel;
    logic [7:0] w_src;

    always_comb begin
      w_sel = 1'b0;
      w_src = i_wdata[8*gi +: 8];
      case (i_size)
        SZ_BYTE: begin
          w_sel = (i_offs == 2'(gi));
          w_src = i_wdata[7:0];
        end
        SZ_HALF: begin
          w_sel = (i_offs[1] == 1'(gi / 2));
          w_src = i_wdata[8*(gi % 2) +: 8];
        end
        SZ_WORD: w_sel = 1'b1;
        default: ;
      endcase
    end

    assign o_st_data[8*gi +: 8] = w_sel ? w_src : i_rdata[8*gi +: 8];
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit FSM: latches one request, runs the memory read / write / RMW
// sequence against a synchronous-read word memory and returns one response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 2048
) (
  input logic  clk,
  input logic  rst_n,
  lsu_if.slave bus
);

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

  state_e      r_state;
  state_e      w_state_next;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merged;
  logic [31:0] r_rdata;
  logic [1:0]  r_err;

  logic        w_hs;
  logic        w_word_st;
  logic [1:0]  w_err;
  logic [31:0] w_ld_data;
  logic [31:0] w_st_data;

  lsu_align u_align (
    .i_rdata    (bus.mem_rdata),
    .i_wdata    (r_wdata),
    .i_offs     (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_ld_data  (w_ld_data),
    .o_st_data  (w_st_data)
  );

  // Gating with rst_n keeps req_ready low while reset is held.
  assign bus.req_ready = (r_state == IDLE) && rst_n;
  assign w_hs          = bus.req_ready && bus.req_valid;
  assign w_err         = check_req(bus.req_size, bus.req_addr, ADDR_LIMIT);
  assign w_word_st     = r_we && (r_size == SZ_WORD);

  always_comb begin
    w_state_next  = r_state;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'd0;
    bus.mem_wdata = 32'd0;
    bus.rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hs)
          w_state_next = (w_err != ERR_OK) ? RESP : ACCESS;
      end
      ACCESS: begin
        bus.mem_addr = {2'b00, r_addr[31:2]};
        if (w_word_st) begin
          bus.mem_we    = 1'b1;
          bus.mem_wdata = r_wdata;
          w_state_next  = RESP;
        end else begin
          bus.mem_re   = 1'b1;
          w_state_next = RDWAIT;
        end
      end
      RDWAIT: begin
        bus.mem_addr = {2'b00, r_addr[31:2]};
        w_state_next = r_we ? MERGE : RESP;
      end
      MERGE: begin
        bus.mem_addr  = {2'b00, r_addr[31:2]};
        bus.mem_we    = 1'b1;
        bus.mem_wdata = r_merged;
        w_state_next  = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready)
          w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_size     <= SZ_BYTE;
      r_unsigned <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_merged   <= 32'd0;
      r_rdata    <= 32'd0;
      r_err      <= ERR_OK;
    end else begin
      r_state <= w_state_next;
      if (w_hs) begin
        r_we       <= bus.req_we;
        r_size     <= bus.req_size;
        r_unsigned <= bus.req_unsigned;
        r_addr     <= bus.req_addr;
        r_wdata    <= bus.req_wdata;
        r_rdata    <= 32'd0;
        r_err      <= w_err;
      end
      if (r_state == RDWAIT) begin
        if (r_we)
          r_merged <= w_st_data;
        else
          r_rdata <= w_ld_data;
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the execute stage and the word-wide, synchronous-read data memory. Accepts one byte, halfword or word access per transaction over a valid/ready request channel. Generates word-indexed memory cycles and performs read-modify-write for sub-word stores. Returns aligned and extended load data, or an error code, over a valid/ready response channel.

## Interface
- `MEM_WORDS`, 2048: data memory depth in 32-bit words; the byte address limit is `MEM_WORDS*4`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads only: zero-extend when high, sign-extend when low.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  32  load result; 0 for stores and errors.
- `rsp_err`  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal size.
- `mem_addr`  out  32  word index = `req_addr >> 2`.
- `mem_re`  out  1  read strobe.
- `mem_we`  out  1  write strobe.
- `mem_wdata`  out  32  full-word write data.
- `mem_rdata`  in  32  memory read data, valid the cycle after the `mem_re` cycle.

## Operation
- FSM states: IDLE, ACCESS, RDWAIT, MERGE, RESP.
- **IDLE**
  - `req_ready`=1.
  - On handshake, latch the request and check for errors in priority order: illegal size, then misaligned (half with `addr[0]`≠0, word with `addr[1:0]`≠0), then out of range (`addr >= MEM_WORDS*4`).
  - On any error, go to RESP with the error code.
  - Otherwise go to ACCESS.
- **ACCESS**
  - `mem_addr` is driven from the latched address.
  - Load or sub-word store: `mem_re`=1, then go to RDWAIT.
  - Word store: `mem_we`=1, `mem_wdata`=`req_wdata`, then go to RESP.
- **RDWAIT**
  - `mem_rdata` is valid in this state.
  - Load: extract the addressed lane, extend it, register the result into `rsp_rdata`, then go to RESP.
  - Sub-word store: register the merged word, then go to MERGE.
- **MERGE**
  - `mem_we`=1 with the merged word; `mem_addr` is unchanged.
  - Then go to RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_rdata` and `rsp_err` are held stable.
  - On `rsp_ready`, go to IDLE.
  - No new request is accepted until the state returns to IDLE; there is no bypass.
- **Byte lanes:** little-endian. Byte k occupies bits [8k+7:8k]. A halfword at `addr[1]`=h occupies bits [16h+15:16h].
- **Merge:** only the addressed lane is replaced with the low bits of `req_wdata`; all other lanes keep their `mem_rdata` value.
- **Strobe decoding:** `mem_re`, `mem_we` and `mem_addr` are decoded combinationally from the state and latched registers. They are 0 in IDLE, RESP and any error path.
- **Errors:** no memory strobe is ever asserted for an erroring request.

## Timing
- The request is accepted in cycle A.
- `rsp_valid` first rises in:
  - load: A+3
  - word store: A+2
  - sub-word store: A+4 (memory read in A+1, merged write in A+3)
  - error: A+1
- **Reset values:** state IDLE; `req_ready`=0 during reset and 1 after release; `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=00; `mem_re`=`mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- **Reset mid-transaction:**
  - `mem_we` and `mem_re` deassert asynchronously.
  - The transaction is discarded and produces no response.
  - Any partially performed RMW leaves memory unwritten.
- **Backpressure:** `rsp_ready` low holds RESP indefinitely with outputs stable. `req_ready` stays 0 throughout.
- **Simultaneous events:** `req_valid` during non-IDLE states is ignored. The requester must hold its signals until it sees `req_ready`.

## Structure
- Package `lsu_pkg` holds:
  - size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`)
  - error codes (`ERR_OK`, `ERR_MISALIGN`, `ERR_RANGE`, `ERR_SIZE`)
  - the state enum
- Sub-module `lsu_align` is purely combinational. It computes:
  - load extract and extend from (`mem_rdata`, `addr[1:0]`, size, unsigned)
  - store merge from (`mem_rdata`, `req_wdata`, `addr[1:0]`, size)
- The FSM, latches and handshakes stay in `load_store_unit`.

## Test plan
In all scenarios the memory model is preloaded with word 5 = 32'h80F1_A27C.
- **Signed byte load:** LB signed, addr 0x15. Expect `mem_re` in A+1 with `mem_addr`=5; `rsp_valid` in A+3 with `rsp_rdata`=32'hFFFF_FFA2 and `rsp_err`=00.
- **Unsigned halfword load:** LHU, addr 0x16. Expect `rsp_rdata`=32'h0000_80F1. LH at the same address expects 32'hFFFF_80F1.
- **Byte store (RMW):** SB, addr 0x17, data 32'h1234_5655. Expect `mem_re` in A+1, then `mem_we` in A+3 with `mem_wdata`=32'h55F1_A27C. `rsp_valid` in A+4; a subsequent LW at 0x14 returns 32'h55F1_A27C.
- **Error responses:**
  - LW at 0x22: `rsp_err`=01 in A+1, with no `mem_re`/`mem_we` ever asserted.
  - SW at 0x2000 with `MEM_WORDS`=2048: `rsp_err`=10.
  - `req_size`=11: `rsp_err`=11.
- **Backpressure:** hold `rsp_ready`=0 for 4 cycles after an LW at 0x14. Expect `rsp_valid`=1 and `rsp_rdata`=32'h80F1_A27C stable throughout, with `req_ready`=0. The response completes on the cycle `rsp_ready` rises.
- **Reset during MERGE:** assert `rst_n`=0 while in MERGE. Expect `mem_we` to drop without waiting for a clock edge, `rsp_valid`=0, and `req_ready`=1 on the first cycle after release.
